priority_encoder_sanjeev: RTL

// - Sequential N-to-log2(N) priority encoder. It is the encode-side counterpart of the team's 2-to-4 enable decoder.
// - Captures rising edges on request lines into sticky pending bits.
// - Presents the winning index as a binary code under a valid/ready handshake.
// - Clears the served pending bit when the consumer accepts the code.
// - Typical use: the code feeds a downstream decoder stage.

---
 rtl/priority_encoder_sanjeev_if.sv | 21 ++
 rtl/priority_encoder_sanjeev.sv | 121 ++++++++++++
 2 files changed

// File: rtl/priority_encoder_sanjeev_if.sv
// Code handshake between priority_encoder_sanjeev (master) and its consumer (slave).
// A code transfers on every rising clk edge where valid=1 and ready=1; while valid=1 and ready=0, y holds still; ready is ignored when valid=0.
interface priority_encoder_sanjeev_if #(
    parameter int CODE_W = 2
);
    logic [CODE_W-1:0] y;
    logic              valid;
    logic              ready;

    modport master (
        output y,
        output valid,
        input  ready
    );

    modport slave (
        input  y,
        input  valid,
        output ready
    );
endinterface

// File: rtl/priority_encoder_sanjeev.sv
// Sequential N_IN-to-CODE_W priority encoder with sticky pending bits and a valid/ready code output.
// Optional macro PRIENC_ROUND_ROBIN_EN selects rotating priority instead of fixed highest-index priority.
module priority_encoder_sanjeev #(
    parameter int N_IN   = 4,
    parameter int CODE_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      e,
    input  logic [N_IN-1:0]           d,
    output logic [N_IN-1:0]           pend,
    output logic                      ovf,
    output logic                      state_dbg,
    priority_encoder_sanjeev_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    logic [N_IN-1:0]   d_q;
    logic [N_IN-1:0]   rise;
    logic [N_IN-1:0]   clr;
    logic [CODE_W-1:0] y_q;
    logic [CODE_W-1:0] win;
    logic              valid_q;
    logic              accept;

    assign accept = valid_q & bus.ready;

    always_comb begin
        rise = '0;
        if (e) begin
            rise = d & ~d_q;
        end
    end

    // The served bit is dropped only when the consumer takes the code.
    always_comb begin
        clr = '0;
        if (accept) begin
            clr[y_q] = 1'b1;
        end
    end

`ifdef PRIENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0] last_q;

    // Search ascends from last+1 with wrap; walking k downwards lets the nearest hit win.
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = (int'(last_q) + 1 + k) % N_IN;
            if (pend[idx]) begin
                win = idx[CODE_W-1:0];
            end
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (pend[i]) begin
                win = i[CODE_W-1:0];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            y_q     <= '0;
            valid_q <= 1'b0;
            pend    <= '0;
            ovf     <= 1'b0;
            d_q     <= '0;
`ifdef PRIENC_ROUND_ROBIN_EN
            last_q  <= '0;
`endif
        end else begin
            d_q  <= d;
            // A rise on a bit cleared this same cycle re-arms it and is not an overflow.
            pend <= (pend & ~clr) | rise;
            if (|(rise & pend & ~clr)) begin
                ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|pend) begin
                        y_q     <= win;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
`ifdef PRIENC_ROUND_ROBIN_EN
                        last_q  <= y_q;
`endif
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.y     = y_q;
    assign bus.valid = valid_q;
    assign state_dbg = logic'(state);

endmodule
